// File: rtl/rs_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_slot_scheduler
// Description : Two-entry reservation station with CDB operand capture and a
//               valid/ready issue port. Define RS_AGE_ORDER_EN for oldest-ready
//               selection; otherwise slot 1 has fixed priority over slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_slot_scheduler #(
    parameter int TAG_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_0_valid,
    input  logic [75:0] in_0_data,
    input  logic        in_1_valid,
    input  logic [75:0] in_1_data,
    output logic        empty_0,
    output logic        empty_1,
    input  logic        cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        flush,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [75:0] issue_data,
    output logic        issue_slot,
    output logic        wr_err
);

    localparam int c_RS1_V   = 10;
    localparam int c_RS1_VAL = 11;
    localparam int c_RS2_V   = 43;
    localparam int c_RS2_VAL = 44;

    logic [1:0]  r_occ;
    logic [75:0] r_payload_0;
    logic [75:0] r_payload_1;
    logic        r_wr_err;

    logic [1:0]  w_ready;
    logic [1:0]  w_wr_ok;
    logic [1:0]  w_occ_nxt;
    logic        w_sel;
    logic        w_fire;
    logic [75:0] w_payload_0_nxt;
    logic [75:0] w_payload_1_nxt;

    // Same capture rule serves both dispatch-time bypass and stored wake-up.
    function automatic logic [75:0] f_capture(input logic [75:0] d);
        logic [75:0] r;
        r = d;
        if (cdb_valid && !d[c_RS1_V] && d[c_RS1_VAL +: TAG_W] == cdb_tag) begin
            r[c_RS1_VAL +: 32] = cdb_data;
            r[c_RS1_V]         = 1'b1;
        end
        if (cdb_valid && !d[c_RS2_V] && d[c_RS2_VAL +: TAG_W] == cdb_tag) begin
            r[c_RS2_VAL +: 32] = cdb_data;
            r[c_RS2_V]         = 1'b1;
        end
        return r;
    endfunction

    assign w_ready[0] = r_occ[0] & r_payload_0[c_RS1_V] & r_payload_0[c_RS2_V];
    assign w_ready[1] = r_occ[1] & r_payload_1[c_RS1_V] & r_payload_1[c_RS2_V];
    assign w_fire     = issue_valid & issue_ready;
    assign w_wr_ok    = {in_1_valid & ~r_occ[1], in_0_valid & ~r_occ[0]};

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr_ok[0]) begin
            w_occ_nxt[0] = 1'b1;
        end else if (w_fire && !w_sel) begin
            w_occ_nxt[0] = 1'b0;
        end
        if (w_wr_ok[1]) begin
            w_occ_nxt[1] = 1'b1;
        end else if (w_fire && w_sel) begin
            w_occ_nxt[1] = 1'b0;
        end
        if (flush) begin
            w_occ_nxt = 2'b00;
        end
    end

    assign w_payload_0_nxt = f_capture(w_wr_ok[0] ? in_0_data : r_payload_0);
    assign w_payload_1_nxt = f_capture(w_wr_ok[1] ? in_1_data : r_payload_1);

`ifdef RS_AGE_ORDER_EN
    logic r_old;
    logic w_old_nxt;

    always_comb begin
        w_old_nxt = r_old;
        if (!flush) begin
            if (&w_wr_ok) begin
                w_old_nxt = 1'b1;
            end else if (w_occ_nxt == 2'b11) begin
                if (w_wr_ok[0]) begin
                    w_old_nxt = 1'b1;
                end else if (w_wr_ok[1]) begin
                    w_old_nxt = 1'b0;
                end
            end else if (w_occ_nxt == 2'b01) begin
                w_old_nxt = 1'b0;
            end else if (w_occ_nxt == 2'b10) begin
                w_old_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_old <= 1'b0;
        end else begin
            r_old <= w_old_nxt;
        end
    end

    assign w_sel = (&w_ready) ? r_old : w_ready[1];
`else
    assign w_sel = w_ready[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ       <= 2'b00;
            r_payload_0 <= '0;
            r_payload_1 <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_payload_0 <= w_payload_0_nxt;
            r_payload_1 <= w_payload_1_nxt;
            if ((in_0_valid & r_occ[0]) | (in_1_valid & r_occ[1])) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    assign empty_0     = ~r_occ[0];
    assign empty_1     = ~r_occ[1];
    assign issue_valid = |w_ready;
    assign issue_slot  = w_sel;
    assign issue_data  = !issue_valid ? '0 : (w_sel ? r_payload_1 : r_payload_0);
    assign wr_err      = r_wr_err;

endmodule
`default_nettype wire
